// File: rtl/game_pkg.sv
// Shared encodings for the game memory arbiter: update opcodes, fixed word
// addresses, FSM states and requester identifiers.
package game_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;

    localparam int SCORE_ADDR = 0;
    localparam int TOP_ADDR   = 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        WAIT_A,
        RD_B,
        WAIT_B,
        WRITE,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        REQ_UPD,
        REQ_CMT,
        REQ_DSP
    } req_t;

endpackage

// File: rtl/score_mem_arbiter.sv
// Single owner of the game_mem RAM: serves score updates, top-score commits and
// display reads one at a time with fixed priority upd > cmt > dsp.
module score_mem_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 2,
    parameter int SCORE_ADDR = game_pkg::SCORE_ADDR,
    parameter int TOP_ADDR   = game_pkg::TOP_ADDR
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              upd_req,
    input  logic [1:0]        upd_op,
    input  logic [DATA_W-1:0] upd_delta,
    output logic              upd_done,
    input  logic              cmt_req,
    output logic              cmt_done,
    output logic              cmt_new_record,
    input  logic              dsp_req,
    input  logic [ADDR_W-1:0] dsp_addr,
    output logic [DATA_W-1:0] dsp_data,
    output logic              dsp_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy
);
    import game_pkg::state_t;
    import game_pkg::req_t;
    import game_pkg::OP_ADD;
    import game_pkg::OP_CLEAR;
    import game_pkg::IDLE;
    import game_pkg::RD_A;
    import game_pkg::WAIT_A;
    import game_pkg::RD_B;
    import game_pkg::WAIT_B;
    import game_pkg::WRITE;
    import game_pkg::DONE;
    import game_pkg::REQ_UPD;
    import game_pkg::REQ_CMT;
    import game_pkg::REQ_DSP;

    localparam logic [ADDR_W-1:0] SCORE_A   = ADDR_W'(SCORE_ADDR);
    localparam logic [ADDR_W-1:0] TOP_A     = ADDR_W'(TOP_ADDR);
    localparam logic [1:0]        WAIT_LOAD = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t            state_reg;
    req_t              kind_reg;
    logic [DATA_W-1:0] delta_reg;
    logic [DATA_W-1:0] score_reg;
    logic [1:0]        wait_reg;
    logic [DATA_W:0]   sum_next;

    // One extra bit catches the carry that forces saturation.
    assign sum_next = {1'b0, mem_q} + {1'b0, delta_reg};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            kind_reg       <= REQ_UPD;
            delta_reg      <= '0;
            score_reg      <= '0;
            wait_reg       <= '0;
            mem_address    <= '0;
            mem_data       <= '0;
            mem_wren       <= 1'b0;
            upd_done       <= 1'b0;
            cmt_done       <= 1'b0;
            cmt_new_record <= 1'b0;
            dsp_data       <= '0;
            dsp_done       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            mem_wren       <= 1'b0;
            upd_done       <= 1'b0;
            cmt_done       <= 1'b0;
            cmt_new_record <= 1'b0;
            dsp_done       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (upd_req) begin
                        kind_reg  <= REQ_UPD;
                        delta_reg <= upd_delta;
                        busy      <= 1'b1;
                        if (upd_op == OP_ADD) begin
                            mem_address <= SCORE_A;
                            state_reg   <= RD_A;
                        end else if (upd_op == OP_CLEAR) begin
                            mem_address <= SCORE_A;
                            mem_data    <= '0;
                            mem_wren    <= 1'b1;
                            state_reg   <= WRITE;
                        end else begin
                            upd_done  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end else if (cmt_req) begin
                        kind_reg    <= REQ_CMT;
                        mem_address <= SCORE_A;
                        busy        <= 1'b1;
                        state_reg   <= RD_A;
                    end else if (dsp_req) begin
                        kind_reg    <= REQ_DSP;
                        mem_address <= dsp_addr;
                        busy        <= 1'b1;
                        state_reg   <= RD_A;
                    end
                end
                RD_A, WAIT_A: begin
                    if (state_reg == RD_A && RD_LAT > 1) begin
                        wait_reg  <= WAIT_LOAD;
                        state_reg <= WAIT_A;
                    end else if (state_reg == WAIT_A && wait_reg != 2'd0) begin
                        wait_reg <= wait_reg - 2'd1;
                    end else begin
                        case (kind_reg)
                            REQ_UPD: begin
                                mem_data  <= sum_next[DATA_W] ? {DATA_W{1'b1}} : sum_next[DATA_W-1:0];
                                mem_wren  <= 1'b1;
                                state_reg <= WRITE;
                            end
                            REQ_CMT: begin
                                score_reg   <= mem_q;
                                mem_address <= TOP_A;
                                state_reg   <= RD_B;
                            end
                            default: begin
                                dsp_data  <= mem_q;
                                dsp_done  <= 1'b1;
                                state_reg <= DONE;
                            end
                        endcase
                    end
                end
                RD_B, WAIT_B: begin
                    if (state_reg == RD_B && RD_LAT > 1) begin
                        wait_reg  <= WAIT_LOAD;
                        state_reg <= WAIT_B;
                    end else if (state_reg == WAIT_B && wait_reg != 2'd0) begin
                        wait_reg <= wait_reg - 2'd1;
                    end else if (score_reg > mem_q) begin
                        mem_data  <= score_reg;
                        mem_wren  <= 1'b1;
                        state_reg <= WRITE;
                    end else begin
                        cmt_done  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                WRITE: begin
                    // Only updates and record-breaking commits ever write.
                    if (kind_reg == REQ_CMT) begin
                        cmt_done       <= 1'b1;
                        cmt_new_record <= 1'b1;
                    end else begin
                        upd_done <= 1'b1;
                    end
                    state_reg <= DONE;
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_mem_arbiter.sv
// Randomized bench for score_mem_arbiter with a behavioural game_mem and a
// word-level reference of score/top contents, latencies and write counts.
module tb_score_mem_arbiter;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              upd_req = 1'b0;
    logic [1:0]        upd_op = 2'b00;
    logic [DATA_W-1:0] upd_delta = '0;
    logic              upd_done;
    logic              cmt_req = 1'b0;
    logic              cmt_done;
    logic              cmt_new_record;
    logic              dsp_req = 1'b0;
    logic [ADDR_W-1:0] dsp_addr = '0;
    logic [DATA_W-1:0] dsp_data;
    logic              dsp_done;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;
    logic              busy;

    int errors = 0;
    int checks = 0;

    score_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .resetn(resetn),
        .upd_req(upd_req), .upd_op(upd_op), .upd_delta(upd_delta), .upd_done(upd_done),
        .cmt_req(cmt_req), .cmt_done(cmt_done), .cmt_new_record(cmt_new_record),
        .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_data(dsp_data), .dsp_done(dsp_done),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // game_mem: address sampled at the edge, q one register later (RD_LAT=2).
    logic [DATA_W-1:0] gm [32];
    logic [DATA_W-1:0] q_pipe = '0;
    logic              clr = 1'b0;
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [DATA_W-1:0] pre_val = '0;
    int cyc = 0, wren_cnt = 0, upd_cnt = 0, cmt_cnt = 0, dsp_cnt = 0;

    assign mem_q = q_pipe;

    always @(posedge clk) begin
        q_pipe <= gm[mem_address];
        if (clr) begin
            for (int i = 0; i < 32; i++) gm[i] <= '0;
        end else if (pre_we) begin
            gm[pre_addr] <= pre_val;
        end else if (mem_wren) begin
            gm[mem_address] <= mem_data;
        end
        cyc      <= cyc + 1;
        wren_cnt <= wren_cnt + int'(mem_wren);
        upd_cnt  <= upd_cnt + int'(upd_done);
        cmt_cnt  <= cmt_cnt + int'(cmt_done);
        dsp_cnt  <= dsp_cnt + int'(dsp_done);
    end

    // Reference contents of the RAM, tracked as plain integers.
    int ref_mem [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic preset(input int addr, input int val);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = 5'(addr);
        pre_val  = 8'(val);
        @(negedge clk);
        pre_we = 1'b0;
        ref_mem[addr] = val;
    endtask

    function automatic logic done_of(input int k);
        return (k == 0) ? upd_done : (k == 1) ? cmt_done : dsp_done;
    endfunction

    // k: 0=update, 1=commit, 2=display
    task automatic txn(input int k, input logic [1:0] op, input logic [7:0] delta, input logic [4:0] addr);
        int  exp_lat, exp_wr, lat, w0, start, s;
        int  exp_dsp;
        logic exp_rec, got_rec;
        logic [7:0] got_dsp;
        bit  seen;
        exp_wr = 0; exp_rec = 1'b0; exp_dsp = 0; lat = 0; seen = 0;
        got_rec = 1'b0; got_dsp = '0;
        if (k == 0) begin
            if (op == 2'b00) begin
                exp_lat = 4; exp_wr = 1;
                s = ref_mem[0] + int'(delta);
                ref_mem[0] = (s > 255) ? 255 : s;
            end else if (op == 2'b01) begin
                exp_lat = 2; exp_wr = 1; ref_mem[0] = 0;
            end else begin
                exp_lat = 1;
            end
        end else if (k == 1) begin
            if (ref_mem[0] > ref_mem[1]) begin
                exp_lat = 6; exp_wr = 1; exp_rec = 1'b1; ref_mem[1] = ref_mem[0];
            end else begin
                exp_lat = 5;
            end
        end else begin
            exp_lat = 3; exp_dsp = ref_mem[addr];
        end
        @(negedge clk);
        w0 = wren_cnt; start = cyc;
        if (k == 0) begin upd_req = 1'b1; upd_op = op; upd_delta = delta; end
        else if (k == 1) cmt_req = 1'b1;
        else begin dsp_req = 1'b1; dsp_addr = addr; end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("busy_after_grant", 32'(busy), 32'd1);
                upd_delta = 8'($urandom);
                dsp_addr  = 5'($urandom);
            end
            if (done_of(k)) begin
                seen = 1; lat = cyc - start;
                got_rec = cmt_new_record; got_dsp = dsp_data;
            end
        end
        upd_req = 1'b0; cmt_req = 1'b0; dsp_req = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("write_count", 32'(wren_cnt - w0), 32'(exp_wr));
        if (k == 1) check("new_record", 32'(got_rec), 32'(exp_rec));
        if (k == 2) check("dsp_data", 32'(got_dsp), 32'(exp_dsp));
        @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
        check("score_word", 32'(gm[0]), 32'(ref_mem[0]));
        check("top_word", 32'(gm[1]), 32'(ref_mem[1]));
        $display("txn kind=%0d op=%0d delta=%0d addr=%0d lat=%0d score=%0d top=%0d",
                 k, op, delta, addr, lat, gm[0], gm[1]);
    endtask

    task automatic simultaneous(input logic [7:0] delta);
        int order [$];
        int s, exp_dsp, o0, o1, o2;
        s = ref_mem[0] + int'(delta);
        ref_mem[0] = (s > 255) ? 255 : s;
        if (ref_mem[0] > ref_mem[1]) ref_mem[1] = ref_mem[0];
        exp_dsp = ref_mem[0];
        @(negedge clk);
        upd_req = 1'b1; upd_op = 2'b00; upd_delta = delta;
        cmt_req = 1'b1;
        dsp_req = 1'b1; dsp_addr = 5'd0;
        for (int i = 0; i < 60 && order.size() < 3; i++) begin
            @(negedge clk);
            if (upd_done) begin order.push_back(0); upd_req = 1'b0; end
            if (cmt_done) begin order.push_back(1); cmt_req = 1'b0; end
            if (dsp_done) begin order.push_back(2); dsp_req = 1'b0; end
        end
        upd_req = 1'b0; cmt_req = 1'b0; dsp_req = 1'b0;
        o0 = (order.size() > 0) ? order[0] : 9;
        o1 = (order.size() > 1) ? order[1] : 9;
        o2 = (order.size() > 2) ? order[2] : 9;
        check("order_first", 32'(o0), 32'd0);
        check("order_second", 32'(o1), 32'd1);
        check("order_third", 32'(o2), 32'd2);
        check("simul_dsp_data", 32'(dsp_data), 32'(exp_dsp));
        @(negedge clk);
        check("simul_score", 32'(gm[0]), 32'(ref_mem[0]));
        check("simul_top", 32'(gm[1]), 32'(ref_mem[1]));
        $display("simultaneous delta=%0d served=%0d,%0d,%0d dsp_data=%0d", delta, o0, o1, o2, dsp_data);
    endtask

    task automatic reset_mid_add();
        int w0, u0;
        preset(0, 20);
        @(negedge clk);
        w0 = wren_cnt; u0 = upd_cnt;
        upd_req = 1'b1; upd_op = 2'b00; upd_delta = 8'd3;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0; upd_req = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wren", 32'(mem_wren), 32'd0);
        check("rst_outs", 32'({upd_done, cmt_done, cmt_new_record, dsp_done}), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_dsp_data", 32'(dsp_data), 32'd0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_write", 32'(wren_cnt - w0), 32'd0);
        check("rst_no_done", 32'(upd_cnt - u0), 32'd0);
        check("rst_score_kept", 32'(gm[0]), 32'(ref_mem[0]));
        $display("reset during WAIT_A: writes=%0d done=%0d score=%0d", wren_cnt - w0, upd_cnt - u0, gm[0]);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 0;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_outs", 32'({mem_wren, upd_done, cmt_done, cmt_new_record, dsp_done}), 32'd0);
        check("reset_dsp_data", 32'(dsp_data), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        txn(0, 2'b00, 8'd5, 5'd0);
        txn(0, 2'b00, 8'd5, 5'd0);
        preset(0, 250);
        txn(0, 2'b00, 8'd10, 5'd0);
        txn(0, 2'b01, 8'd0, 5'd0);
        preset(0, 42);
        preset(1, 30);
        txn(1, 2'b00, 8'd0, 5'd0);
        preset(1, 42);
        txn(1, 2'b00, 8'd0, 5'd0);
        preset(1, 77);
        txn(2, 2'b00, 8'd0, 5'd1);
        txn(0, 2'b11, 8'd9, 5'd0);
        simultaneous(8'd7);
        reset_mid_add();

        for (int n = 0; n < 30; n++) begin
            int k;
            k = int'($urandom_range(2, 0));
            if ($urandom_range(7, 0) == 0) preset(0, int'($urandom_range(255, 200)));
            if (k == 2) preset(int'($urandom_range(5, 2)), int'($urandom_range(255, 0)));
            txn(k, 2'($urandom_range(3, 0)), 8'($urandom), 5'($urandom_range(5, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
